keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and produces the `key_code` / `key_pressed` pair consumed by the segment display driver. It drives one active-low column at a time, decodes each complete scan into none / single key / multiple keys, and commits a result only after it has been stable for a programmable number of scans. The block sits between the board keypad pins and the display, and is the producer side of the key interface.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_debounce.sv | 86 ++++++++
 rtl/keypad_scanner.sv | 118 +++++++++++
 tb/tb_keypad_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned CNT_W    = 4;

  localparam logic [CODE_W-1:0] KEY_STAR = 4'hE;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'hF;

  // One full-scan decode: none, exactly one key (code), or several keys.
  typedef struct packed {
    logic              none;
    logic              multi;
    logic [CODE_W-1:0] code;
  } scan_result_t;

  localparam scan_result_t RESULT_NONE = '{none: 1'b1, multi: 1'b0, code: 4'h0};

  // Key map indexed [row][col].
  localparam logic [CODE_W-1:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1,     4'h2, 4'h3,     4'hA},
    '{4'h4,     4'h5, 4'h6,     4'hB},
    '{4'h7,     4'h8, 4'h9,     4'hC},
    '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
  };

  // Two non-multi results match if both are none, or both carry the same code.
  function automatic logic same_result(input scan_result_t a, input scan_result_t b);
    return (a.none == b.none) && (a.none || (a.code == b.code));
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-rate debouncer: candidate register, stable counter and commit logic.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_scan_done,
  input  scan_result_t      i_result,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_pressed,
  output logic              o_key_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  scan_result_t      r_cand;
  logic [CNT_W-1:0]  r_count;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_pressed;
  logic              r_key_valid;

  scan_result_t      w_cand_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CODE_W-1:0] w_code_nxt;
  logic              w_pressed_nxt;
  logic              w_valid_nxt;
  logic              w_commit;

  // Next-state: update candidate/count once per scan and decide on a commit.
  always_comb begin
    w_cand_nxt    = r_cand;
    w_count_nxt   = r_count;
    w_code_nxt    = r_key_code;
    w_pressed_nxt = r_key_pressed;
    w_valid_nxt   = 1'b0;
    w_commit      = 1'b0;

    if (i_scan_done) begin
      if (i_result.multi) begin
        w_cand_nxt  = RESULT_NONE;
        w_count_nxt = '0;
      end else if (!same_result(i_result, r_cand)) begin
        w_cand_nxt  = i_result;
        w_count_nxt = CNT_W'(1);
        w_commit    = (CNT_MAX == CNT_W'(1));
      end else if (r_count != CNT_MAX) begin
        w_count_nxt = CNT_W'(r_count + CNT_W'(1));
        w_commit    = (CNT_W'(r_count + CNT_W'(1)) == CNT_MAX);
      end

      if (w_commit) begin
        if (w_cand_nxt.none) begin
          w_pressed_nxt = 1'b0;
        end else if (!r_key_pressed || (r_key_code != w_cand_nxt.code)) begin
          w_code_nxt    = w_cand_nxt.code;
          w_pressed_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand        <= RESULT_NONE;
      r_count       <= '0;
      r_key_code    <= KEY_HASH;
      r_key_pressed <= 1'b0;
      r_key_valid   <= 1'b0;
    end else begin
      r_cand        <= w_cand_nxt;
      r_count       <= w_count_nxt;
      r_key_code    <= w_code_nxt;
      r_key_pressed <= w_pressed_nxt;
      r_key_valid   <= w_valid_nxt;
    end
  end

  assign o_key_code    = r_key_code;
  assign o_key_pressed = r_key_pressed;
  assign o_key_valid   = r_key_valid;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row sync, column drive, scan accumulate/decode, debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows_in,
  output logic [3:0]  cols_out,
  output logic [3:0]  key_code,
  output logic        key_pressed,
  output logic        key_valid
);

  localparam int unsigned STEP_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCAN_DIV - 1);
  localparam int unsigned HIT_W = NUM_ROWS * NUM_COLS;

  logic [NUM_ROWS-1:0] r_sync1;
  logic [NUM_ROWS-1:0] r_sync2;
  logic [STEP_W-1:0]   r_step;
  logic [1:0]          r_col;
  logic [NUM_COLS-1:0] r_cols;
  logic [HIT_W-1:0]    r_hits;

  logic                w_sample;
  logic                w_scan_done;
  logic [HIT_W-1:0]    w_hits_all;
  logic [1:0]          w_hit_cnt;
  logic [CODE_W-1:0]   w_hit_code;
  scan_result_t        w_result;

  assign w_sample    = (r_step == STEP_LAST);
  assign w_scan_done = w_sample && (r_col == 2'd3);

  // Two-flop synchroniser for the asynchronous, active-low rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= rows_in;
      r_sync2 <= r_sync1;
    end
  end

  // Step and column counters; column drive rotates one low bit per dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
      r_col  <= 2'd0;
      r_cols <= 4'b1110;
    end else if (w_sample) begin
      r_step <= '0;
      r_col  <= 2'(r_col + 2'd1);
      r_cols <= {r_cols[2:0], r_cols[3]};
    end else begin
      r_step <= STEP_W'(r_step + STEP_W'(1));
    end
  end

  // Hit map including the column currently being sampled (index = {row, col}).
  always_comb begin
    w_hits_all = r_hits;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_hits_all[{2'(r), r_col}] = r_hits[{2'(r), r_col}] | ~r_sync2[r];
    end
  end

  // Scan accumulator: OR in the sampled column, clear when the scan closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits <= '0;
    end else if (w_scan_done) begin
      r_hits <= '0;
    end else if (w_sample) begin
      r_hits <= w_hits_all;
    end
  end

  // Decoder: count intersections (saturating at 2) and map the first one.
  always_comb begin
    w_hit_cnt  = 2'd0;
    w_hit_code = 4'h0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (w_hits_all[{2'(r), 2'(c)}]) begin
          if (w_hit_cnt == 2'd0) begin
            w_hit_code = KEY_MAP[r][c];
          end
          if (w_hit_cnt != 2'd2) begin
            w_hit_cnt = 2'(w_hit_cnt + 2'd1);
          end
        end
      end
    end
    w_result.none  = (w_hit_cnt == 2'd0);
    w_result.multi = (w_hit_cnt == 2'd2);
    w_result.code  = (w_hit_cnt == 2'd1) ? w_hit_code : 4'h0;
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_scan_done   (w_scan_done),
    .i_result      (w_result),
    .o_key_code    (key_code),
    .o_key_pressed (key_pressed),
    .o_key_valid   (key_valid)
  );

  assign cols_out = r_cols;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and commit scoreboard.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB      = 3;
  localparam int          MAX_LAT  = 131;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       key_valid;

  logic [15:0] keys;          // bit row*4+col = key held
  logic [3:0]  exp_q [$];     // expected commit codes
  int          total = 0;
  int          bad = 0;
  int          n_valid = 0;
  logic        prev_valid = 1'b0;
  logic        watch_drop = 1'b0;
  int          drops = 0;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;
  vec_t vecs [16];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rows_in     (rows_in),
    .cols_out    (cols_out),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .key_valid   (key_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low if any held key in it sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rows_in[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !cols_out[c]) rows_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each strobe pops the next expected code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_valid++;
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      check("valid_with_pressed", 32'(key_pressed), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: key_code=%0h with no commit expected (t=%0t)", key_code, $time);
      end else begin
        check("commit_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
    if (watch_drop && key_pressed !== 1'b1) drops++;
    prev_valid = key_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_release(input int max_cyc, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (key_pressed === 1'b0) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    int         v0;
    int         early;
    logic [3:0] ecol;

    vecs = '{
      '{0, 0, 4'h1}, '{0, 1, 4'h2}, '{0, 2, 4'h3}, '{0, 3, 4'hA},
      '{1, 0, 4'h4}, '{1, 1, 4'h5}, '{1, 2, 4'h6}, '{1, 3, 4'hB},
      '{2, 0, 4'h7}, '{2, 1, 4'h8}, '{2, 2, 4'h9}, '{2, 3, 4'hC},
      '{3, 0, 4'hE}, '{3, 1, 4'h0}, '{3, 2, 4'hF}, '{3, 3, 4'hD}
    };

    keys  = '0;
    rst_n = 1'b0;
    idle(3);
    check("rst_cols", 32'(cols_out), 32'hE);
    check("rst_code", 32'(key_code), 32'hF);
    check("rst_pressed", 32'(key_pressed), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    rst_n = 1'b1;

    // Reset mid-scan, then column walk from column 0, step 0.
    idle(13);
    rst_n = 1'b0;
    #1;
    check("midrst_cols", 32'(cols_out), 32'hE);
    check("midrst_code", 32'(key_code), 32'hF);
    check("midrst_pressed", 32'(key_pressed), 32'd0);
    check("midrst_valid", 32'(key_valid), 32'd0);
    idle(2);
    rst_n = 1'b1;
    check("walk_cols_0", 32'(cols_out), 32'hE);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      ecol = 4'b0001 << ((n / 8) % 4);
      ecol = ~ecol;
      check("walk_cols", 32'(cols_out), 32'(ecol));
    end

    // Every key: press, commit within bound, release, code holds.
    for (int k = 0; k < 16; k++) begin
      idle(int'($urandom_range(0, 40)));
      keys = 16'(1) << (vecs[k].row * 4 + vecs[k].col);
      exp_q.push_back(vecs[k].code);
      wait_valid(MAX_LAT, lat);
      check("press_in_time", 32'(lat != 0), 32'd1);
      check("press_not_early", 32'(lat > 64), 32'd1);
      idle(2);
      check("held_code", 32'(key_code), 32'(vecs[k].code));
      check("held_pressed", 32'(key_pressed), 32'd1);
      keys = '0;
      wait_release(MAX_LAT, lat);
      check("release_in_time", 32'(lat != 0), 32'd1);
      check("release_code_holds", 32'(key_code), 32'(vecs[k].code));
    end

    // Bounce on '*' then hold: exactly one commit.
    idle(20);
    v0 = n_valid;
    exp_q.push_back(4'hE);
    for (int i = 0; i < 20; i++) begin
      keys = (i % 2 == 0) ? 16'h1000 : 16'h0000;
      idle(10);
    end
    keys = 16'h1000;
    idle(150);
    check("bounce_pulses", 32'(n_valid - v0), 32'd1);
    check("bounce_code", 32'(key_code), 32'hE);
    check("bounce_pressed", 32'(key_pressed), 32'd1);
    keys = '0;
    wait_release(MAX_LAT, lat);
    check("bounce_release", 32'(lat != 0), 32'd1);

    // Keys 1 and 2 together: no commit; release 1 commits 2.
    idle(17);
    v0 = n_valid;
    keys = 16'h0003;
    idle(300);
    check("multi_no_pulse", 32'(n_valid - v0), 32'd0);
    check("multi_not_pressed", 32'(key_pressed), 32'd0);
    keys = 16'h0002;
    exp_q.push_back(4'h2);
    wait_valid(MAX_LAT, lat);
    check("multi_then_single", 32'(lat != 0), 32'd1);
    keys = '0;
    wait_release(MAX_LAT, lat);
    check("multi_release", 32'(lat != 0), 32'd1);

    // '#' held, add '0', drop '#': F then 0 with key_pressed staying high.
    idle(9);
    v0 = n_valid;
    keys = 16'h4000;
    exp_q.push_back(4'hF);
    wait_valid(MAX_LAT, lat);
    check("change_first", 32'(lat != 0), 32'd1);
    watch_drop = 1'b1;
    keys = 16'h6000;
    idle(200);
    check("change_multi_hold_code", 32'(key_code), 32'hF);
    keys = 16'h2000;
    exp_q.push_back(4'h0);
    wait_valid(MAX_LAT, lat);
    check("change_second", 32'(lat != 0), 32'd1);
    idle(2);
    watch_drop = 1'b0;
    check("change_pulses", 32'(n_valid - v0), 32'd2);
    check("change_no_drop", 32'(drops), 32'd0);
    check("change_code", 32'(key_code), 32'h0);
    keys = '0;
    wait_release(MAX_LAT, lat);
    check("change_release", 32'(lat != 0), 32'd1);

    // Key 9 then reset before commit; full debounce needed after release.
    idle(5);
    v0 = n_valid;
    keys = 16'h0400;
    idle(60);
    check("rstdeb_no_commit", 32'(n_valid - v0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstdeb_pressed", 32'(key_pressed), 32'd0);
    check("rstdeb_code", 32'(key_code), 32'hF);
    idle(2);
    rst_n = 1'b1;
    exp_q.push_back(4'h9);
    early = 0;
    for (int n = 1; n <= 96; n++) begin
      @(negedge clk);
      if (n < 96 && key_valid === 1'b1) early++;
      if (n == 96) check("rstdeb_commit_at_scan3", 32'(key_valid), 32'd1);
    end
    check("rstdeb_not_early", 32'(early), 32'd0);
    idle(1);
    check("rstdeb_held", 32'(key_pressed), 32'd1);
    keys = '0;
    idle(10);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
